// File: rtl/axi_ar_xbar.sv
// axi_ar_xbar: round-robin AXI AR crossbar, NUM_M masters to NUM_S slaves, one registered request in flight
module axi_ar_xbar #(
  parameter int NUM_M = 3,
  parameter int NUM_S = 6,
  parameter int IDW = 4,
  parameter int MIDW = $clog2(NUM_M),
  parameter int AW = 32,
  parameter logic [NUM_S*AW-1:0] SLV_BASE = {NUM_S{32'h0}},
  parameter logic [NUM_S*AW-1:0] SLV_MASK = {NUM_S{32'hFFFF_0000}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_M*IDW-1:0]  m_arid,
  input  logic [NUM_M*AW-1:0]   m_araddr,
  input  logic [NUM_M*4-1:0]    m_arlen,
  input  logic [NUM_M*3-1:0]    m_arsize,
  input  logic [NUM_M*2-1:0]    m_arburst,
  input  logic [NUM_M-1:0]      m_arvalid,
  output logic [NUM_M-1:0]      m_arready,
  output logic [IDW+MIDW-1:0]   s_arid,
  output logic [AW-1:0]         s_araddr,
  output logic [3:0]            s_arlen,
  output logic [2:0]            s_arsize,
  output logic [1:0]            s_arburst,
  output logic [NUM_S-1:0]      s_arvalid,
  input  logic [NUM_S-1:0]      s_arready,
  output logic                  err_valid,
  output logic [IDW+MIDW-1:0]   err_id,
  output logic [3:0]            err_len,
  input  logic                  err_ready
);
  typedef enum logic [1:0] {IDLE, SEND, ERR} state_t;
  state_t state;
  logic [MIDW-1:0] rr_ptr, gnt, idx;
  logic [MIDW:0] sum;
  logic found, take, done;
  logic [AW-1:0] addr;
  logic [NUM_S-1:0] hit, first;
  always_comb begin
    found = 1'b0;
    gnt = '0;
    sum = '0;
    idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      sum = {1'b0, rr_ptr} + (MIDW+1)'(i);
      idx = sum >= (MIDW+1)'(NUM_M) ? MIDW'(sum - (MIDW+1)'(NUM_M)) : MIDW'(sum);
      if (!found && m_arvalid[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
    addr = m_araddr[gnt*AW +: AW];
    hit = '0;
    for (int s = 0; s < NUM_S; s++) hit[s] = (addr & SLV_MASK[s*AW +: AW]) == SLV_BASE[s*AW +: AW];
    // isolate the lowest set bit so overlapping regions resolve to the lowest slave
    first = hit & (~hit + NUM_S'(1));
  end
  assign take = state == IDLE && found;
  assign done = (state == SEND && |(s_arvalid & s_arready)) || (state == ERR && err_ready);
  assign m_arready = take ? NUM_M'(1) << gnt : '0;
  assign err_id = s_arid;
  assign err_len = s_arlen;
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (take) rr_ptr <= gnt == MIDW'(NUM_M - 1) ? '0 : gnt + MIDW'(1);
    if (rst || done) begin
      state <= IDLE;
      s_arid <= '0;
      s_araddr <= '0;
      s_arlen <= '0;
      s_arsize <= '0;
      s_arburst <= '0;
      s_arvalid <= '0;
      err_valid <= 1'b0;
    end else if (take) begin
      state <= |hit ? SEND : ERR;
      s_arid <= {gnt, m_arid[gnt*IDW +: IDW]};
      s_araddr <= addr;
      s_arlen <= m_arlen[gnt*4 +: 4];
      s_arsize <= m_arsize[gnt*3 +: 3];
      s_arburst <= m_arburst[gnt*2 +: 2];
      s_arvalid <= first;
      err_valid <= ~|hit;
    end
  end
endmodule

// File: tb/tb_axi_ar_xbar.sv
// tb_axi_ar_xbar: directed and random AR crossbar bench against a transaction-level reference model
module tb_axi_ar_xbar;
  localparam int NM = 3, NS = 6, IDW = 4, MIDW = 2, AW = 32;
  localparam logic [NS*AW-1:0] BASE = {32'h0005_0000, 32'h0004_0000, 32'h0003_0000,
                                       32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [NM*IDW-1:0] m_arid;
  logic [NM*AW-1:0] m_araddr;
  logic [NM*4-1:0] m_arlen;
  logic [NM*3-1:0] m_arsize;
  logic [NM*2-1:0] m_arburst;
  logic [NM-1:0] m_arvalid, m_arready;
  logic [IDW+MIDW-1:0] s_arid, err_id;
  logic [AW-1:0] s_araddr;
  logic [3:0] s_arlen, err_len;
  logic [2:0] s_arsize;
  logic [1:0] s_arburst;
  logic [NS-1:0] s_arvalid, s_arready;
  logic err_valid, err_ready;
  logic [IDW-1:0] id [NM];
  logic [31:0] ad [NM];
  logic [3:0] ln [NM];
  logic [2:0] sz [NM];
  logic [1:0] bu [NM];
  logic [NM-1:0] vld;
  always_comb begin
    m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    for (int m = 0; m < NM; m++) begin
      m_arid[m*IDW +: IDW] = id[m];
      m_araddr[m*AW +: AW] = ad[m];
      m_arlen[m*4 +: 4] = ln[m];
      m_arsize[m*3 +: 3] = sz[m];
      m_arburst[m*2 +: 2] = bu[m];
    end
    m_arvalid = vld;
  end
  axi_ar_xbar #(.NUM_M(NM), .NUM_S(NS), .IDW(IDW), .AW(AW), .SLV_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready), .err_valid(err_valid),
    .err_id(err_id), .err_len(err_len), .err_ready(err_ready));
  int n_tests = 0, n_fail = 0;
  bit have = 0;
  int ptr = 0, r_m, r_slv, last_g, cyc = 0, n_grant = 0, n_done = 0, n_drop = 0;
  logic [IDW-1:0] r_id;
  logic [31:0] r_addr;
  logic [3:0] r_len;
  logic [2:0] r_sz;
  logic [1:0] r_bu;
  int waitc [NM];
  int glog [$], gcyc [$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int pick();
    for (int k = 0; k < NM; k++) if (vld[(ptr + k) % NM]) return (ptr + k) % NM;
    return -1;
  endfunction
  function automatic int decode(input logic [31:0] a);
    return a[31:16] < NS ? int'(a[31:16]) : -1;
  endfunction
  task automatic cycle();
    int g;
    logic [MIDW+IDW-1:0] mid;
    #3;
    g = have ? -1 : pick();
    last_g = rst ? -1 : g;
    chk("m_arready", m_arready, g >= 0 ? NM'(1) << g : '0);
    mid = {MIDW'(r_m), r_id};
    if (rst) begin
      if (have) n_drop++;
      have = 0;
      ptr = 0;
    end else if (have) begin
      if (r_slv >= 0 ? s_arready[r_slv] : err_ready) begin
        chk("hs_id", r_slv >= 0 ? s_arid : err_id, mid);
        n_done++;
        have = 0;
      end
    end else if (g >= 0) begin
      for (int m = 0; m < NM; m++) if (m != g && vld[m]) waitc[m]++;
      waitc[g] = 0;
      for (int m = 0; m < NM; m++) chk("starve", waitc[m] < NM, 1);
      glog.push_back(g);
      gcyc.push_back(cyc);
      have = 1; r_m = g; r_id = id[g]; r_addr = ad[g]; r_len = ln[g]; r_sz = sz[g]; r_bu = bu[g];
      r_slv = decode(ad[g]);
      ptr = (g + 1) % NM;
      n_grant++;
    end
    @(posedge clk);
    #1;
    cyc++;
    mid = {MIDW'(r_m), r_id};
    chk("s_arvalid", s_arvalid, have && r_slv >= 0 ? NS'(1) << r_slv : '0);
    chk("err_valid", err_valid, have && r_slv < 0);
    chk("onehot", $countones(s_arvalid) <= 1, 1);
    if (!have || r_slv >= 0)
      chk("payload", {s_arid, s_araddr, s_arlen, s_arsize, s_arburst},
          have ? {mid, r_addr, r_len, r_sz, r_bu} : '0);
    else chk("err_pay", {err_id, err_len}, {mid, r_len});
  endtask
  task automatic set_m(input int m, input logic [3:0] i, input logic [31:0] a, input logic [3:0] l);
    vld[m] = 1'b1; id[m] = i; ad[m] = a; ln[m] = l; sz[m] = 3'd2; bu[m] = 2'd1;
  endtask
  initial begin
    for (int m = 0; m < NM; m++) begin
      id[m] = '0; ad[m] = '0; ln[m] = '0; sz[m] = '0; bu[m] = '0; waitc[m] = 0;
    end
    vld = '0; s_arready = '0; err_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) cycle();
    chk("rst_err_id", err_id, '0);
    rst = 1'b0;
    // single request to S1
    set_m(0, 4'h5, 32'h0001_0000, 4'h2);
    cycle();
    vld = '0;
    chk("s1_sel", s_arvalid, 6'b000010);
    chk("s1_id", s_arid, 6'h05);
    s_arready = '1;
    cycle();
    // all masters valid, slaves always ready: rr 0,1,2,...
    rst = 1'b1; cycle(); rst = 1'b0;
    glog.delete(); gcyc.delete();
    for (int m = 0; m < NM; m++) set_m(m, 4'(m + 1), 32'h0000_0100 * m, 4'h1);
    repeat (12) cycle();
    chk("rr_count", glog.size(), 6);
    for (int i = 0; i < glog.size(); i++) chk("rr_order", glog[i], i % NM);
    for (int i = 1; i < gcyc.size(); i++) chk("rr_gap", gcyc[i] - gcyc[i-1], 2);
    // back-pressure on S2
    vld = '0; s_arready = '0;
    cycle();
    set_m(1, 4'hA, 32'h0002_0040, 4'h7);
    cycle();
    set_m(0, 4'h3, 32'h0000_0000, 4'h0);
    vld[1] = 1'b0;
    repeat (5) begin
      cycle();
      chk("hold_sel", s_arvalid, 6'b000100);
      chk("hold_addr", s_araddr, 32'h0002_0040);
      chk("hold_rdy", m_arready, '0);
    end
    s_arready = 6'b000100;
    cycle();
    vld = '0;
    s_arready = '1;
    repeat (3) cycle();
    // unmapped address
    set_m(2, 4'h9, 32'hFFFF_0000, 4'h3);
    cycle();
    vld = '0;
    repeat (3) begin
      chk("err_v", err_valid, 1'b1);
      chk("err_len", err_len, 4'h3);
      chk("err_id", err_id, {2'd2, 4'h9});
      chk("err_nos", s_arvalid, '0);
      cycle();
    end
    err_ready = 1'b1;
    cycle();
    // reset during SEND drops the request
    s_arready = '0;
    set_m(0, 4'h6, 32'h0003_0010, 4'h1);
    cycle();
    vld = '0;
    cycle();
    set_m(1, 4'h1, 32'h0004_0000, 4'h0);
    set_m(2, 4'h2, 32'h0005_0000, 4'h0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_flush", s_arvalid, '0);
    cycle();
    chk("rst_gnt", last_g, 1);
    // random traffic
    for (int c = 0; c < 10000; c++) begin
      if (last_g >= 0) vld[last_g] = 1'b0;
      for (int m = 0; m < NM; m++)
        if (!vld[m] && $urandom_range(0, 1) == 1)
          set_m(m, 4'($urandom), {16'($urandom_range(0, 7)), 16'($urandom)}, 4'($urandom));
      s_arready = NS'($urandom);
      err_ready = 1'($urandom);
      cycle();
    end
    vld = '0; s_arready = '1; err_ready = 1'b1;
    repeat (3) cycle();
    chk("drain", n_done + n_drop, n_grant);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
